// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   - One-hot mem_cmd encodings (MNONE, MREAD, MWRITE).
//   - Memory-mapped I/O addresses (LED_ADDR, SW_ADDR).
//   - Responder state type (IDLE, WAIT, RESP).
package mem_pkg;

    localparam logic [2:0] MNONE  = 3'b001;
    localparam logic [2:0] MREAD  = 3'b010;
    localparam logic [2:0] MWRITE = 3'b100;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus between the CPU (master) and the memory responder (slave).
//   mem_cmd    : one-hot command from the CPU (MNONE / MREAD / MWRITE)
//   mem_addr   : word address
//   write_data : store data
//   read_data  : load data, valid while ready=1
//   ready      : one-cycle completion pulse
//   busy       : high from acceptance until ready
interface mem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [2:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;
    logic              busy;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, ready, busy
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, ready, busy
    );
endinterface

// File: rtl/ram_sp.sv
// Single-port RAM with synchronous read and write.
//   clk   : rising-edge clock
//   en    : read enable; rdata updates on the edge when en=1 and we=0
//   we    : write enable; mem[addr] <= wdata (rdata holds its value)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
// Contents are not reset.
module ram_sp #(
    parameter int DATA_W    = 16,
    parameter int RAM_DEPTH = 256,
    localparam int AW       = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU memory bus. Serves one read or write per
// transaction from on-chip RAM (addresses 0..RAM_DEPTH-1), an LED output
// register (LED_ADDR) or a switch input port (SW_ADDR), after WAIT_STATES
// extra cycles, and signals completion with a one-cycle ready pulse.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mem_responder_if slave (mem_cmd, mem_addr, write_data,
//           read_data, ready, busy)
//   sw    : switch inputs, sampled on the edge entering RESP
//   leds  : LED register
//   err   : unmapped-access flag, pulses with ready
//
// Build option: define MEM_RESPONDER_ERR_EN to drive err for unmapped
// accesses and writes to SW_ADDR; otherwise err is tied low.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 16,
    parameter int RAM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus,
    input  logic [7:0]     sw,
    output logic [7:0]     leds,
    output logic           err
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    state_t            state;
    logic [2:0]        wcnt;

    // Transaction captured on the acceptance edge
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic [DATA_W-1:0] rd_hold;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] io_rdata;

    logic              in_idle;
    logic              accept;
    logic              resp_entry;

    // "Effective" transaction: with WAIT_STATES=0 the edge that enters RESP is
    // the acceptance edge itself, so the bus must be used before it has been
    // captured. In every other state the captured copy is used.
    logic              eff_write;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic              eff_ram;
    logic              eff_led;
    logic              eff_sw;
    logic              cap_ram;

    logic              ram_en;
    logic              ram_we;

    assign in_idle = (state == IDLE);
    assign accept  = in_idle && ((bus.mem_cmd == MREAD) || (bus.mem_cmd == MWRITE));

    assign resp_entry = (in_idle && accept && (WAIT_STATES == 0)) ||
                        ((state == WAIT) && (wcnt == 3'(WAIT_STATES - 1)));

    assign eff_write = in_idle ? (bus.mem_cmd == MWRITE) : cap_write;
    assign eff_addr  = in_idle ? bus.mem_addr   : cap_addr;
    assign eff_wdata = in_idle ? bus.write_data : cap_wdata;

    assign eff_ram = (32'(eff_addr) < RAM_DEPTH);
    assign eff_led = (eff_addr == ADDR_W'(LED_ADDR));
    assign eff_sw  = (eff_addr == ADDR_W'(SW_ADDR));
    assign cap_ram = (32'(cap_addr) < RAM_DEPTH);

    assign io_rdata = eff_led ? {{(DATA_W-8){1'b0}}, leds} :
                      eff_sw  ? {{(DATA_W-8){1'b0}}, sw}   :
                                '0;

    // The RAM read is launched on the acceptance edge so its registered output
    // is already valid in the RESP cycle even with no wait states.
    assign ram_en = accept && !eff_write && eff_ram;
    assign ram_we = resp_entry && eff_write && eff_ram;

    ram_sp #(
        .DATA_W    (DATA_W),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (eff_addr[RAM_AW-1:0]),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write <= (bus.mem_cmd == MWRITE);
            cap_addr  <= bus.mem_addr;
            cap_wdata <= bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            leds    <= '0;
            rd_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= (WAIT_STATES == 0) ? RESP : WAIT;
                        wcnt  <= '0;
                    end
                end
                WAIT: begin
                    if (wcnt == 3'(WAIT_STATES - 1)) begin
                        state <= RESP;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (resp_entry && eff_write && eff_led) begin
                leds <= eff_wdata[7:0];
            end

            // I/O and unmapped reads are settled when RESP is entered; a RAM
            // read is shown straight from the RAM during RESP and copied into
            // the hold register as RESP ends, so the value persists until the
            // next read completes.
            if (resp_entry && !eff_write && !eff_ram) begin
                rd_hold <= io_rdata;
            end
            if ((state == RESP) && !cap_write && cap_ram) begin
                rd_hold <= ram_rdata;
            end
        end
    end

    assign bus.read_data = ((state == RESP) && !cap_write && cap_ram) ? ram_rdata : rd_hold;
    assign bus.ready     = (state == RESP);
    assign bus.busy      = !in_idle;

`ifdef MEM_RESPONDER_ERR_EN
    logic cap_led;
    logic cap_sw;

    assign cap_led = (cap_addr == ADDR_W'(LED_ADDR));
    assign cap_sw  = (cap_addr == ADDR_W'(SW_ADDR));
    assign err     = (state == RESP) &&
                     (!(cap_ram || cap_led || cap_sw) || (cap_write && cap_sw));
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (WAIT_STATES=1 and 0) driven by
// directed and random transactions, checked each cycle against a
// transaction-level model, plus literal expectations for key scenarios.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int WS0 = 1;
    localparam int WS1 = 0;
`ifdef MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [7:0] sw;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  cmd_a [2];
    logic [8:0]  addr_a [2];
    logic [15:0] wd_a [2];

    logic        o_rdy [2];
    logic        o_busy [2];
    logic        o_err [2];
    logic [7:0]  o_leds [2];
    logic [15:0] o_rd [2];

    mem_responder_if #(.ADDR_W(9), .DATA_W(16)) bus0 ();
    mem_responder_if #(.ADDR_W(9), .DATA_W(16)) bus1 ();

    assign bus0.mem_cmd    = cmd_a[0];
    assign bus0.mem_addr   = addr_a[0];
    assign bus0.write_data = wd_a[0];
    assign bus1.mem_cmd    = cmd_a[1];
    assign bus1.mem_addr   = addr_a[1];
    assign bus1.write_data = wd_a[1];
    assign o_rdy[0]  = bus0.ready;
    assign o_busy[0] = bus0.busy;
    assign o_rd[0]   = bus0.read_data;
    assign o_rdy[1]  = bus1.ready;
    assign o_busy[1] = bus1.busy;
    assign o_rd[1]   = bus1.read_data;

    mem_responder #(.ADDR_W(9), .DATA_W(16), .RAM_DEPTH(256), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .sw(sw), .leds(o_leds[0]), .err(o_err[0])
    );
    mem_responder #(.ADDR_W(9), .DATA_W(16), .RAM_DEPTH(256), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .sw(sw), .leds(o_leds[1]), .err(o_err[1])
    );

    function automatic int ws(input int g);
        return (g == 0) ? WS0 : WS1;
    endfunction

    // ---------------- behavioural model ----------------
    int          m_ph [2];    // 0 idle, 1 waiting, 2 responding
    int          m_left [2];  // edges still to go before the response edge
    logic        m_wr [2];
    logic [8:0]  m_a [2];
    logic [15:0] m_d [2];
    logic [15:0] mram [2][256];
    logic        e_rdy [2];
    logic        e_busy [2];
    logic        e_err [2];
    logic [7:0]  e_leds [2];
    logic [15:0] e_rd [2];

    function automatic logic is_err(input logic wr, input logic [8:0] a);
        logic mapped;
        mapped = (a < 9'd256) || (a == LED_ADDR) || (a == SW_ADDR);
        return ERR_EN && (!mapped || (wr && a == SW_ADDR));
    endfunction

    task automatic resp(input int g, input logic wr, input logic [8:0] a, input logic [15:0] d);
        e_rdy[g] <= 1'b1;
        e_err[g] <= is_err(wr, a);
        if (wr) begin
            if (a < 9'd256)         mram[g][a[7:0]] <= d;
            else if (a == LED_ADDR) e_leds[g] <= d[7:0];
        end else begin
            if (a < 9'd256)         e_rd[g] <= mram[g][a[7:0]];
            else if (a == LED_ADDR) e_rd[g] <= {8'h00, e_leds[g]};
            else if (a == SW_ADDR)  e_rd[g] <= {8'h00, sw};
            else                    e_rd[g] <= 16'h0000;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < 2; g++) begin
                m_ph[g] <= 0; m_left[g] <= 0;
                e_rdy[g] <= 1'b0; e_busy[g] <= 1'b0; e_err[g] <= 1'b0;
                e_leds[g] <= 8'h00; e_rd[g] <= 16'h0000;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                case (m_ph[g])
                    0: if (cmd_a[g] == MREAD || cmd_a[g] == MWRITE) begin
                        m_wr[g] <= (cmd_a[g] == MWRITE);
                        m_a[g] <= addr_a[g];
                        m_d[g] <= wd_a[g];
                        e_busy[g] <= 1'b1;
                        if (ws(g) == 0) begin
                            resp(g, cmd_a[g] == MWRITE, addr_a[g], wd_a[g]);
                            m_ph[g] <= 2;
                        end else begin
                            m_left[g] <= ws(g);
                            m_ph[g] <= 1;
                        end
                    end
                    1: if (m_left[g] == 1) begin
                        resp(g, m_wr[g], m_a[g], m_d[g]);
                        m_ph[g] <= 2;
                    end else begin
                        m_left[g] <= m_left[g] - 1;
                    end
                    default: begin
                        e_rdy[g] <= 1'b0; e_busy[g] <= 1'b0; e_err[g] <= 1'b0;
                        m_ph[g] <= 0;
                    end
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    int checks = 0;
    int errors = 0;
    int pin_seq = 0;
    int pin_done = 0;
    string pin_name;
    logic [31:0] pin_act, pin_exp;

    task automatic cmp(input string n, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", n, g, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            cmp("ready", g, 32'(o_rdy[g]), 32'(e_rdy[g]));
            cmp("busy", g, 32'(o_busy[g]), 32'(e_busy[g]));
            cmp("err", g, 32'(o_err[g]), 32'(e_err[g]));
            cmp("leds", g, 32'(o_leds[g]), 32'(e_leds[g]));
            cmp("read_data", g, 32'(o_rd[g]), 32'(e_rd[g]));
        end
        if (pin_seq != pin_done) begin
            pin_done = pin_seq;
            cmp(pin_name, -1, pin_act, pin_exp);
        end
    end

    // Literal expectation, evaluated by the compare process at the next negedge
    task automatic pin(input string n, input logic [31:0] act, input logic [31:0] exp);
        pin_name = n; pin_act = act; pin_exp = exp;
        pin_seq++;
        @(negedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    // One transaction on dut g; holds the command until ready (bounded).
    task automatic txn(input int g, input logic [2:0] c, input logic [8:0] a, input logic [15:0] d,
                       input int swv, output int lat, output logic [15:0] rd,
                       output logic er, output logic seen);
        bit got;
        @(posedge clk); #1;
        cmd_a[g] = c; addr_a[g] = a; wd_a[g] = d;
        sw = (swv < 0) ? 8'($urandom) : 8'(swv);
        lat = 0; rd = '0; er = 1'b0; seen = 1'b0; got = 1'b0;
        if (c == MREAD || c == MWRITE) begin
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                lat++;
                if (o_rdy[g]) begin
                    got = 1'b1;
                    break;
                end
                addr_a[g] = 9'($urandom);
                wd_a[g] = 16'($urandom);
                if (swv < 0) sw = 8'($urandom);
            end
            rd = o_rd[g]; er = o_err[g];
            cmd_a[g] = MNONE;
            if (!got) pin("ready_timeout", 32'd0, 32'd1);
        end else begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                seen |= o_busy[g] | o_rdy[g];
            end
            cmd_a[g] = MNONE;
        end
    endtask

    task automatic held(input int g, output int gap);
        int r1, r2;
        r1 = -1; r2 = -1;
        @(posedge clk); #1;
        cmd_a[g] = MREAD; addr_a[g] = 9'h005;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (o_rdy[g]) begin
                if (r1 < 0) r1 = cyc;
                else begin
                    r2 = cyc;
                    break;
                end
            end
        end
        cmd_a[g] = MNONE;
        gap = (r2 < 0) ? -1 : r2 - r1;
    endtask

    int lat, gap;
    logic [15:0] rd;
    logic er, seen;

    initial begin
        reset = 1'b0;
        sw = 8'h00;
        for (int g = 0; g < 2; g++) begin
            cmd_a[g] = MNONE; addr_a[g] = '0; wd_a[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        pin("reset_busy", 32'(o_busy[0]), 32'd0);
        pin("reset_ready", 32'(o_rdy[0]), 32'd0);
        pin("reset_leds", 32'(o_leds[0]), 32'd0);
        pin("reset_read_data", 32'(o_rd[1]), 32'd0);
        pin("reset_err", 32'(o_err[1]), 32'd0);
        reset = 1'b1;

        // Preload every RAM word so all later reads have a known value
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 256; a++)
                txn(g, MWRITE, 9'(a), (a == 16) ? 16'h0000 : 16'($urandom), -1, lat, rd, er, seen);

        txn(0, MWRITE, 9'h005, 16'hBEEF, -1, lat, rd, er, seen);
        txn(0, MREAD, 9'h005, 16'h0000, -1, lat, rd, er, seen);
        pin("ws1_read_latency", 32'(lat), 32'd2);
        pin("ws1_read_data", 32'(rd), 32'h0000BEEF);

        txn(1, MWRITE, 9'h100, 16'h00A5, -1, lat, rd, er, seen);
        pin("ws0_write_latency", 32'(lat), 32'd1);
        pin("ws0_leds", 32'(o_leds[1]), 32'h000000A5);
        txn(1, MREAD, 9'h100, 16'h0000, -1, lat, rd, er, seen);
        pin("ws0_led_read", 32'(rd), 32'h000000A5);

        txn(1, MREAD, 9'h140, 16'h0000, 8'h3C, lat, rd, er, seen);
        pin("sw_read", 32'(rd), 32'h0000003C);

        held(0, gap);
        pin("held_gap_ws1", 32'(gap), 32'd3);
        held(1, gap);
        pin("held_gap_ws0", 32'(gap), 32'd2);

        txn(0, MREAD, 9'h1FF, 16'h0000, -1, lat, rd, er, seen);
        pin("unmapped_read_data", 32'(rd), 32'd0);
        pin("unmapped_read_err", 32'(er), 32'(ERR_EN));

        txn(0, MWRITE, 9'h100, 16'h005A, -1, lat, rd, er, seen);
        txn(0, MWRITE, 9'h140, 16'h0011, -1, lat, rd, er, seen);
        pin("sw_write_leds", 32'(o_leds[0]), 32'h0000005A);
        pin("sw_write_err", 32'(er), 32'(ERR_EN));

        txn(0, 3'b011, 9'h005, 16'h0000, -1, lat, rd, er, seen);
        pin("bad_cmd_ignored", 32'(seen), 32'd0);

        // Reset during the WAIT cycle of a write to 0x010 (which holds 0)
        @(posedge clk); #1;
        cmd_a[0] = MWRITE; addr_a[0] = 9'h010; wd_a[0] = 16'h1234;
        @(posedge clk); #1;
        pin("busy_in_wait", 32'(o_busy[0]), 32'd1);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            seen |= o_rdy[0];
        end
        cmd_a[0] = MNONE;
        pin("abort_no_ready", 32'(seen), 32'd0);
        pin("abort_busy", 32'(o_busy[0]), 32'd0);
        pin("abort_leds", 32'(o_leds[0]), 32'd0);
        reset = 1'b1;
        txn(0, MREAD, 9'h010, 16'h0000, -1, lat, rd, er, seen);
        pin("abort_ram_unchanged", 32'(rd), 32'd0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            int g, r;
            logic [2:0] c;
            logic [8:0] a;
            logic [2:0] bad [5];
            bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
            g = int'($urandom_range(1, 0));
            r = int'($urandom_range(7, 0));
            c = (r < 3) ? MREAD : (r < 6) ? MWRITE : bad[$urandom_range(4, 0)];
            case ($urandom_range(3, 0))
                0, 1:    a = 9'($urandom_range(255, 0));
                2:       a = LED_ADDR;
                default: a = $urandom_range(1, 0) ? SW_ADDR : 9'($urandom);
            endcase
            txn(g, c, a, 16'($urandom), -1, lat, rd, er, seen);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's memory bus (mem_cmd / mem_addr / write data / read data).
- Accepts one read or write per transaction and serves it from on-chip RAM or two memory-mapped I/O locations: an LED output register and a switch input port.
- Inserts a configurable number of wait states before completing each transaction.
- Signals completion with a one-cycle ready pulse, so the controller can stall on slow memory.

Parameters:
- ADDR_W, 9: address width; matches the CPU's mem_addr.
- DATA_W, 16: word width.
- RAM_DEPTH, 256: RAM words, mapped at addresses 0..RAM_DEPTH-1.
- WAIT_STATES, 1: extra cycles between command acceptance and ready; legal range 0..7.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mem_cmd  input  3  one-hot command: 3'b001 MNONE, 3'b010 MREAD, 3'b100 MWRITE
- mem_addr  input  ADDR_W  word address
- write_data  input  DATA_W  store data (the CPU's datapath out)
- sw  input  8  switch inputs
- read_data  output  DATA_W  load data; valid while ready=1
- ready  output  1  one-cycle completion pulse
- busy  output  1  high from acceptance until ready
- leds  output  8  LED register
- err  output  1  unmapped-access flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - read_data=0, ready=0, busy=0, leds=0, err=0, wait counter=0.
  - RAM contents are not cleared.
- IDLE:
  - mem_cmd==MREAD or MWRITE at a clock edge accepts the command.
  - mem_addr, write_data and cmd are captured into internal registers.
  - busy=1 from the next cycle.
  - Goes to WAIT if WAIT_STATES>0, else to RESP.
  - MNONE, or any non-one-hot value, is ignored; state stays IDLE.
- WAIT:
  - Counter counts 0..WAIT_STATES-1, then the state goes to RESP.
  - Bus inputs are ignored; only the captured values are used.
- RESP (exactly one cycle):
  - ready=1 and busy=1.
  - Write: the memory write or LED update commits on the edge entering RESP.
  - Read: read_data holds the word; it keeps its value until the next read completes.
  - Next state is IDLE unconditionally.
- Latency:
  - ready rises WAIT_STATES+1 cycles after the acceptance edge.
  - Minimum turnaround: one command per WAIT_STATES+2 cycles.
- Address map:
  - RAM: 0..RAM_DEPTH-1.
  - LEDs: 9'h100. Write takes leds=write_data[7:0]. Read returns {8'h00, leds}.
  - Switches: 9'h140. Read returns {8'h00, sw}, sampled in the RESP-entry cycle. Writes are ignored.
  - Any other address is unmapped. Reads return 0; writes are dropped.
- RAM read: synchronous, one cycle.
  - The read is issued on the acceptance edge, so WAIT_STATES=0 still meets the ready timing.
  - The result is registered into read_data.
- Simultaneous events:
  - A command present during WAIT or RESP is not queued.
  - The CPU holds mem_cmd until ready. A command still held in the IDLE cycle after RESP is accepted again. The controller must drop the command on ready.
- Reset mid-transaction:
  - The transaction is aborted.
  - A write is committed only if its RESP-entry edge already occurred.

Optional Feature:
- Macro: MEM_RESPONDER_ERR_EN.
- Defined: err=1 together with ready for any access to an unmapped address or a write to 9'h140; otherwise err=0.
- Undefined: err is tied to 0; unmapped accesses behave as described above.

Decomposition:
- Package mem_pkg holds:
  - the mem_cmd encodings MNONE, MREAD, MWRITE;
  - the address constants LED_ADDR=9'h100 and SW_ADDR=9'h140;
  - a state enum {IDLE, WAIT, RESP}.
- One sub-module, ram_sp: single-port RAM with synchronous read and write, parameterized by DATA_W and RAM_DEPTH, instantiated once.

Test Plan:
- Reset, then WAIT_STATES=1: MWRITE addr 9'h005, data 16'hBEEF; then MREAD 9'h005 → ready on cycle 2 after acceptance, read_data=16'hBEEF.
- WAIT_STATES=0: MWRITE 9'h100, data 16'h00A5 → leds=8'hA5 on the ready cycle; MREAD 9'h100 → read_data=16'h00A5.
- sw=8'h3C, MREAD 9'h140 → read_data=16'h003C; a held command → second ready exactly WAIT_STATES+2 cycles after the first.
- MREAD 9'h1FF → read_data=0; err=1 with ready if MEM_RESPONDER_ERR_EN, else err=0. MWRITE 9'h140 → leds unchanged.
- Assert reset during WAIT of MWRITE 9'h010, data 16'h1234 → ready never pulses, busy=0, leds=0; a later MREAD 9'h010 does not return 16'h1234 (RAM previously preloaded with 16'h0000).
- mem_cmd=3'b011 in IDLE → no acceptance, busy stays 0, no ready.
